program_launcher: RTL and testbench

Front end between the board buttons and the processor's program-select input. It synchronizes and debounces the four program buttons (fib, sort, save, load), then picks one button by fixed priority. It drives `program_selector` with that button's program code for exactly `HOLD_CYCLES` clocks, then returns it to 0. The hold window is long enough for the register file to copy the switch inputs. Reset (BTNC) is not handled here; it arrives on `reset`.

---
 rtl/program_launcher.sv | 144 ++++++++++++++
 tb/tb_program_launcher.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/program_launcher.sv
// Program-select front end: synchronizes and debounces four buttons and
// issues one fixed-length program code per debounced press.
module program_launcher #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        btn_fib,
    input  logic        btn_sort,
    input  logic        btn_save,
    input  logic        btn_load,
    output logic [31:0] program_selector,
    output logic        launch_pulse,
    output logic        busy
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        WAIT_RELEASE
    } state_t;

    logic [3:0]    raw;
    logic [3:0]    s1;
    logic [3:0]    s2;
    logic [3:0]    db;
    logic [CW-1:0] cnt [4];

    assign raw = {btn_load, btn_save, btn_sort, btn_fib};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // Any agreeing sample restarts the count, so short glitches never land.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            db <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (s2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DB_LAST) begin
                    db[i]  <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    state_t        state;
    state_t        state_n;
    logic [2:0]    code_q;
    logic [2:0]    code_n;
    logic [HW-1:0] hold_q;
    logic [HW-1:0] hold_n;
    logic          pulse_q;
    logic          pulse_n;
    logic [3:0]    pick;
    logic [2:0]    pick_code;

    // Isolate the lowest set bit: fib has the highest priority.
    assign pick = db & (~db + 4'd1);

    always_comb begin
        pick_code = 3'd0;
        unique case (1'b1)
            pick[0]: pick_code = 3'd1;
            pick[1]: pick_code = 3'd2;
            pick[2]: pick_code = 3'd3;
            pick[3]: pick_code = 3'd4;
            default: pick_code = 3'd0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            code_q  <= '0;
            hold_q  <= '0;
            pulse_q <= 1'b0;
        end else begin
            state   <= state_n;
            code_q  <= code_n;
            hold_q  <= hold_n;
            pulse_q <= pulse_n;
        end
    end

    always_comb begin
        state_n = state;
        code_n  = code_q;
        hold_n  = hold_q;
        pulse_n = 1'b0;
        unique case (state)
            IDLE: begin
                if (|db) begin
                    state_n = HOLD;
                    code_n  = pick_code;
                    hold_n  = HOLD_LAST;
                    pulse_n = 1'b1;
                end else begin
                    code_n = '0;
                end
            end
            HOLD: begin
                if (hold_q == '0) begin
                    state_n = WAIT_RELEASE;
                    code_n  = '0;
                end else begin
                    hold_n = hold_q - 1'b1;
                end
            end
            WAIT_RELEASE: begin
                code_n = '0;
                if (db == 4'd0) state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                code_n  = '0;
            end
        endcase
    end

    assign program_selector = {29'd0, code_q};
    assign launch_pulse     = pulse_q;
    assign busy             = (state != IDLE);

endmodule

// File: tb/tb_program_launcher.sv
// Bench for program_launcher: directed scenarios plus random button
// activity, compared every clock against a sample-window reference model.
module tb_program_launcher;

    localparam int D = 4;
    localparam int H = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        btn_fib = 1'b0;
    logic        btn_sort = 1'b0;
    logic        btn_save = 1'b0;
    logic        btn_load = 1'b0;
    logic [31:0] program_selector;
    logic        launch_pulse;
    logic        busy;

    always #5 clock = ~clock;

    program_launcher #(
        .DEBOUNCE_CYCLES(D),
        .HOLD_CYCLES    (H)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .btn_fib         (btn_fib),
        .btn_sort        (btn_sort),
        .btn_save        (btn_save),
        .btn_load        (btn_load),
        .program_selector(program_selector),
        .launch_pulse    (launch_pulse),
        .busy            (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: raw samples per edge (newest first); debounced level flips
    // when the D samples seen through the 2-flop delay all disagree.
    logic [3:0] hist [$];
    logic [3:0] mdb;
    int         left;
    int         code;
    bit         waiting;
    bit         mpulse;
    int         pulses;
    int         last_code;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        hist.delete();
        for (int k = 0; k < D + 2; k++) hist.push_back(4'b0);
        mdb     = 4'b0;
        left    = 0;
        code    = 0;
        waiting = 1'b0;
        mpulse  = 1'b0;
    endfunction

    function automatic int prio(input logic [3:0] d);
        for (int i = 0; i < 4; i++) if (d[i]) return i + 1;
        return 0;
    endfunction

    function automatic void model_edge(input logic [3:0] b);
        bit all_diff;
        mpulse = 1'b0;
        if (left > 0) begin
            left--;
            if (left == 0) waiting = 1'b1;
        end else if (waiting) begin
            if (mdb == 4'b0) waiting = 1'b0;
        end else if (mdb != 4'b0) begin
            code   = prio(mdb);
            left   = H;
            mpulse = 1'b1;
        end
        hist.push_front(b);
        void'(hist.pop_back());
        for (int i = 0; i < 4; i++) begin
            all_diff = 1'b1;
            for (int k = 2; k <= D + 1; k++)
                if (hist[k][i] == mdb[i]) all_diff = 1'b0;
            if (all_diff) mdb[i] = ~mdb[i];
        end
    endfunction

    task automatic check_outputs();
        check_eq("selector", program_selector, 32'(left > 0 ? code : 0));
        check_eq("launch_pulse", 32'(launch_pulse), 32'(mpulse));
        check_eq("busy", 32'(busy), 32'(left > 0 || waiting));
        if (launch_pulse) begin
            pulses++;
            last_code = int'(program_selector);
        end
    endtask

    task automatic tick(input logic [3:0] b);
        {btn_load, btn_save, btn_sort, btn_fib} = b;
        @(posedge clock);
        if (reset) model_reset();
        else model_edge(b);
        #1;
        check_outputs();
    endtask

    task automatic async_reset_pulse(input logic [3:0] b);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_outputs();
        tick(b);
        #2;
        reset = 1'b0;
    endtask

    int launch_edge;
    int k;
    logic [3:0] rb;
    int len;

    initial begin
        model_reset();
        #2;
        check_outputs();
        tick(4'b0);
        tick(4'b0);
        #2;
        reset = 1'b0;

        // clean press
        pulses = 0;
        launch_edge = 0;
        for (int i = 1; i <= 20; i++) begin
            tick(4'b0001);
            if (launch_pulse && launch_edge == 0) launch_edge = i;
        end
        check_eq("fib_launch_edge", 32'(launch_edge), 32'd7);
        check_eq("fib_pulses", 32'(pulses), 32'd1);
        repeat (15) tick(4'b0);

        // glitch rejection
        pulses = 0;
        repeat (3) tick(4'b0010);
        repeat (10) tick(4'b0);
        check_eq("glitch_pulses", 32'(pulses), 32'd0);

        // priority, fib during hold ignored
        pulses = 0;
        repeat (7) tick(4'b1010);
        repeat (13) tick(4'b1011);
        repeat (15) tick(4'b0);
        check_eq("prio_pulses", 32'(pulses), 32'd1);
        check_eq("prio_code", 32'(last_code), 32'd2);

        // held button, then new press
        pulses = 0;
        repeat (30) tick(4'b0100);
        check_eq("held_pulses", 32'(pulses), 32'd1);
        check_eq("held_code", 32'(last_code), 32'd3);
        repeat (10) tick(4'b0);
        pulses = 0;
        repeat (10) tick(4'b1000);
        repeat (15) tick(4'b0);
        check_eq("load_pulses", 32'(pulses), 32'd1);
        check_eq("load_code", 32'(last_code), 32'd4);

        // release bounce
        pulses = 0;
        repeat (12) tick(4'b0001);
        for (int i = 0; i < 10; i++)
            tick(((i / 2) % 2) == 0 ? 4'b0000 : 4'b0001);
        repeat (15) tick(4'b0);
        check_eq("bounce_pulses", 32'(pulses), 32'd1);

        // reset in the second hold clock
        k = 0;
        do begin
            tick(4'b0001);
            k++;
        end while (!launch_pulse && k < 20);
        check_eq("pre_reset_launch", 32'(launch_pulse), 32'd1);
        tick(4'b0001);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_eq("async_sel", program_selector, 32'd0);
        check_eq("async_busy", 32'(busy), 32'd0);
        tick(4'b0001);
        tick(4'b0001);
        #2;
        reset = 1'b0;
        launch_edge = 0;
        for (int i = 1; i <= 12; i++) begin
            tick(4'b0001);
            if (launch_pulse && launch_edge == 0) launch_edge = i;
        end
        check_eq("relaunch_edge", 32'(launch_edge), 32'd7);
        repeat (15) tick(4'b0);

        // random activity
        repeat (300) begin
            rb  = 4'($urandom);
            len = $urandom_range(1, 12);
            repeat (len) tick(rb);
            if ($urandom_range(0, 39) == 0) async_reset_pulse(rb);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
